// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm zone controller.
// Holds the FSM state encoding and the default parameter constants.
package alarm_pkg;

  localparam int unsigned N_ZONES_DEF   = 3;
  localparam int unsigned ENTRY_DLY_DEF = 8;
  localparam int unsigned CNT_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMED    = 2'b01,
    ST_ENTRY    = 2'b10,
    ST_ALARM    = 2'b11
  } state_e;

endpackage

// File: rtl/alarm_delay_cnt.sv
// Entry-delay down-counter with a registered zero flag.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   load_i      - load load_val_i (has priority over en_i)
//   load_val_i  - value to load, CNT_W bits
//   en_i        - decrement by one (ignored when already zero)
//   zero_o      - registered flag, high while the count is zero
module alarm_delay_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  // Next count: load wins, decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count and zero flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Intrusion alarm controller: arm/disarm FSM, zone qualification with
// bypass mask, entry delay on zone[0], and sticky zone latch.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   arm, disarm - level requests (disarm has priority)
//   zone        - sensor levels, zone[0] delayed, others instant
//   zone_mask   - 1 = zone bypassed
//   alarma      - siren drive
//   armed       - high in ARMED/ENTRY/ALARM
//   pending     - high in ENTRY
//   arm_fail    - one-cycle pulse when arming is refused
//   zone_latch  - sticky record of triggering zones
//   state       - current FSM state
module alarm_zone_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned N_ZONES   = N_ZONES_DEF,
  parameter int unsigned ENTRY_DLY = ENTRY_DLY_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               disarm,
  input  logic [N_ZONES-1:0] zone,
  input  logic [N_ZONES-1:0] zone_mask,
  output logic               alarma,
  output logic               armed,
  output logic               pending,
  output logic               arm_fail,
  output logic [N_ZONES-1:0] zone_latch,
  output logic [1:0]         state
);

  // All zones except zone[0]; empty when only the door zone exists
  localparam logic [N_ZONES-1:0] INST_MASK = ~N_ZONES'(1);

  state_e             state_q, state_d;
  logic [N_ZONES-1:0] latch_q, latch_d;
  logic               arm_fail_q, arm_fail_d;
  logic               alarma_q, armed_q, pending_q;
  logic [N_ZONES-1:0] act;
  logic               inst_act;
  logic               cnt_load, cnt_en, cnt_zero;

  assign act      = zone & ~zone_mask;
  assign inst_act = |(act & INST_MASK);

  alarm_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(ENTRY_DLY - 1)),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // Next-state, zone latch and arm-fail decode
  always_comb begin
    state_d    = state_q;
    latch_d    = latch_q;
    arm_fail_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    if (disarm) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            if (act == '0) begin
              state_d = ST_ARMED;
              latch_d = '0;
            end else begin
              arm_fail_d = 1'b1;
            end
          end
        end
        ST_ARMED: begin
          latch_d = latch_q | act;
          if (inst_act) begin
            state_d = ST_ALARM;
          end else if (act[0]) begin
            state_d  = ST_ENTRY;
            cnt_load = 1'b1;
          end
        end
        ST_ENTRY: begin
          latch_d = latch_q | act;
          if (inst_act || cnt_zero) begin
            state_d = ST_ALARM;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_ALARM: begin
          latch_d = latch_q | act;
        end
        default: begin
          state_d = ST_DISARMED;
        end
      endcase
    end
  end

  // State and output registers; status outputs track the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DISARMED;
      latch_q    <= '0;
      arm_fail_q <= 1'b0;
      alarma_q   <= 1'b0;
      armed_q    <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      latch_q    <= latch_d;
      arm_fail_q <= arm_fail_d;
      alarma_q   <= (state_d == ST_ALARM);
      armed_q    <= (state_d != ST_DISARMED);
      pending_q  <= (state_d == ST_ENTRY);
    end
  end

  assign alarma     = alarma_q;
  assign armed      = armed_q;
  assign pending    = pending_q;
  assign arm_fail   = arm_fail_q;
  assign zone_latch = latch_q;
  assign state      = state_q;

endmodule
